scalar_hazard_ctrl: RTL and testbench
=====================================

# scalar_hazard_ctrl

Pipeline hazard controller for the scalar core. Tracks destination-register tags of the instructions in EX, MEM and WB and generates the per-operand forwarding selects that drive the operand-bypass muxes. Detects load-use and multi-cycle-operation hazards and sequences the resulting stalls and bubbles. Applies branch flushes. Sits beside the ID/EX pipeline register and is the only source of stall, bubble and forwarding-select signals for the scalar pipe.

## Interface
- REG_AW, 4, register index width
- MC_CYCLES, 4, total EX occupancy of a multi-cycle op; legal range 2..15

- clk  in  1  pipeline clock
- rst_n  in  1  asynchronous, active-low reset
- id_valid  in  1  ID holds a real instruction
- id_rs2, id_rs3  in  REG_AW  source operand indices
- id_use_rs2, id_use_rs3  in  1  operand is actually read
- id_rd  in  REG_AW  destination index
- id_wr  in  1  instruction writes id_rd
- id_is_load  in  1  instruction is a load; result available at end of MEM
- id_is_mc  in  1  multi-cycle EX operation
- flush  in  1  taken branch resolved in EX this cycle
- stall  out  1  hold PC and IF/ID
- bubble  out  1  load NOP into ID/EX
- fwd_sel_r2, fwd_sel_r3  out  2  bypass select: 00 regfile, 01 WB result, 10 MEM result, 11 EX ALU result
- mc_busy  out  1  multi-cycle op occupying EX

## Operation
- Stage tags: EX, MEM and WB each hold {valid, rd, wr, load}.
  - On each edge without stall, ID info shifts into EX, EX into MEM, MEM into WB.
  - EX is loaded invalid when bubble=1.
  - A tag "matches" a source when all of: valid, wr, rd equal to the source index, and the corresponding id_use bit set.
- Forwarding (combinational):
  - Priority EX (11) > MEM (10) > WB (01) > 00.
  - An EX match whose tag has load=1 never selects 11. It raises a load-use hazard instead.
- FSM states: RUN, LDSTALL, MC.
  - RUN, load-use hazard, no flush: stall=1, bubble=1, next state LDSTALL.
  - RUN, id_valid and id_is_mc, no stall: instruction advances into EX; next state MC; counter loaded with MC_CYCLES-1.
  - RUN, flush: bubble=1, stall=0; the ID instruction is squashed. Flush overrides load-use and mc entry.
  - LDSTALL: forwarding is re-evaluated (the load is now in MEM, so select 10); stall=0; next state RUN. One cycle only.
  - MC:
    - stall=1, mc_busy=1. The EX tag is held. MEM receives invalid tags; WB continues to shift.
    - The counter decrements each cycle. When it reaches 1, stall drops and the next state is RUN.
    - flush is ignored in MC; no branch can be in EX.
- Hazards against the held MC op's rd resolve through normal forwarding once it leaves EX.

## Timing
- Reset outputs: stall=0, bubble=0, fwd_sel_r2=fwd_sel_r3=00, mc_busy=0. State RUN, all tag valids 0, counter 0.
- stall, bubble and fwd_sel are combinational from current state, tags and ID inputs. They are valid in the same cycle.
- Load-use penalty: exactly 1 cycle.
- MC op penalty: exactly MC_CYCLES-1 stall cycles.
- Back-to-back MC ops: second enters EX on the cycle stall drops and re-enters MC with no idle cycle.
- Reset asserted mid-stall or in MC: immediate return to reset values. No partial state survives.
- id_valid=0 produces no hazard and no state change other than the tag shift.

## Configuration
- SCALAR_ZERO_REG_EN
  - Defined: register index 0 is hardwired zero. Sources or destinations equal to 0 never match, never forward and never stall.
  - Undefined: index 0 is treated like any other register.

## Test plan
- Reset: assert rst_n=0 mid-MC with counter at 2 -> all outputs 0 and state RUN asynchronously; stays so on release.
- ALU chain: EX tag rd=3, MEM tag rd=3, WB tag rd=3; ID reads rs2=3 -> fwd_sel_r2=11. Remove the EX tag -> 10. Remove the MEM tag -> 01.
- Load-use: load rd=5 in EX; ID rs3=5 with id_use_rs3=1 -> stall=1 and bubble=1 for one cycle, then fwd_sel_r3=10 and stall=0.
- Multi-cycle: MC op, MC_CYCLES=4 -> mc_busy=1 and stall=1 for 3 cycles, then resume. Back-to-back MC op -> no gap.
- Flush priority: flush=1 in the same cycle as a load-use hazard -> bubble=1, stall=0, next state RUN.
- Zero register: EX tag rd=0 with wr=1; ID reads rs2=0 -> fwd_sel_r2=00 with SCALAR_ZERO_REG_EN defined, 11 without it.

Source files
------------

// File: rtl/scalar_hazard_ctrl.sv
// Scalar pipeline hazard controller: EX/MEM/WB tag tracking, operand bypass selects,
// load-use and multi-cycle stall sequencing, branch flush. Option: SCALAR_ZERO_REG_EN.
module scalar_hazard_ctrl #(
  parameter int REG_AW    = 4,
  parameter int MC_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [REG_AW-1:0] id_rs3,
  input  logic              id_use_rs2,
  input  logic              id_use_rs3,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_wr,
  input  logic              id_is_load,
  input  logic              id_is_mc,
  input  logic              flush,
  output logic              stall,
  output logic              bubble,
  output logic [1:0]        fwd_sel_r2,
  output logic [1:0]        fwd_sel_r3,
  output logic              mc_busy
);

  typedef enum logic [1:0] {RUN, LDSTALL, MC} state_t;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic              wr;
    logic              load;
  } tag_t;

  localparam logic [3:0] MC_LOAD = 4'(MC_CYCLES - 1);

  state_t     state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  tag_t       ex_tag, mem_tag, wb_tag;
  logic       ex_hit2, ex_hit3, load_haz, mc_entry;

  function automatic logic src_match(tag_t t, logic [REG_AW-1:0] src, logic use_src);
    logic m;
    m = t.valid && t.wr && (t.rd == src) && use_src;
`ifdef SCALAR_ZERO_REG_EN
    // r0 is hardwired zero: never produced by the pipe, so never forwarded or waited on
    m = m && (src != '0);
`endif
    return m;
  endfunction

  // A load in EX has no result yet; such a match falls through to older stages
  // and is reported as a load-use hazard instead.
  function automatic logic [1:0] fwd_sel(logic [REG_AW-1:0] src, logic use_src);
    if (src_match(ex_tag, src, use_src) && !ex_tag.load) return 2'b11;
    if (src_match(mem_tag, src, use_src))                 return 2'b10;
    if (src_match(wb_tag, src, use_src))                  return 2'b01;
    return 2'b00;
  endfunction

  assign ex_hit2    = src_match(ex_tag, id_rs2, id_use_rs2);
  assign ex_hit3    = src_match(ex_tag, id_rs3, id_use_rs3);
  assign load_haz   = id_valid && ex_tag.load && (ex_hit2 || ex_hit3);
  assign mc_entry   = id_valid && id_is_mc;
  assign fwd_sel_r2 = fwd_sel(id_rs2, id_use_rs2);
  assign fwd_sel_r3 = fwd_sel(id_rs3, id_use_rs3);

  // NOTE: every signal driven here gets a default first so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    stall     = 1'b0;
    bubble    = 1'b0;
    mc_busy   = 1'b0;
    unique case (state)
      RUN: begin
        if (flush) begin
          bubble    = 1'b1;
        end else if (load_haz) begin
          stall     = 1'b1;
          bubble    = 1'b1;
          state_nxt = LDSTALL;
        end else if (mc_entry) begin
          state_nxt = MC;
          cnt_nxt   = MC_LOAD;
        end
      end
      // EX holds a bubble here, so no branch can flush; a multi-cycle op that
      // waited behind the load still has to enter MC or its penalty is lost.
      LDSTALL: begin
        if (mc_entry) begin
          state_nxt = MC;
          cnt_nxt   = MC_LOAD;
        end else begin
          state_nxt = RUN;
        end
      end
      MC: begin
        stall   = 1'b1;
        mc_busy = 1'b1;
        cnt_nxt = cnt - 4'd1;
        if (cnt == 4'd1) state_nxt = RUN;
      end
      default: state_nxt = RUN;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= RUN;
      cnt     <= '0;
      ex_tag  <= '0;
      mem_tag <= '0;
      wb_tag  <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (state == MC) begin
        mem_tag <= '0;
        wb_tag  <= mem_tag;
      end else begin
        ex_tag  <= bubble ? '0 : tag_t'{id_valid, id_rd, id_wr, id_is_load};
        mem_tag <= ex_tag;
        wb_tag  <= mem_tag;
      end
    end
  end

endmodule

// File: tb/tb_scalar_hazard_ctrl.sv
// Self-checking bench for scalar_hazard_ctrl: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a stage-list reference model.
module tb_scalar_hazard_ctrl;

  localparam int REG_AW    = 4;
  localparam int MC_CYCLES = 4;
`ifdef SCALAR_ZERO_REG_EN
  localparam bit ZERO_EN = 1'b1;
`else
  localparam bit ZERO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic id_valid = 1'b0, id_use_rs2 = 1'b0, id_use_rs3 = 1'b0;
  logic [REG_AW-1:0] id_rs2 = '0, id_rs3 = '0, id_rd = '0;
  logic id_wr = 1'b0, id_is_load = 1'b0, id_is_mc = 1'b0, flush = 1'b0;
  logic stall, bubble, mc_busy;
  logic [1:0] fwd_sel_r2, fwd_sel_r3;

  int n_checks = 0;
  int n_errors = 0;

  scalar_hazard_ctrl #(.REG_AW(REG_AW), .MC_CYCLES(MC_CYCLES)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .id_rs2(id_rs2), .id_rs3(id_rs3), .id_use_rs2(id_use_rs2), .id_use_rs3(id_use_rs3),
    .id_rd(id_rd), .id_wr(id_wr), .id_is_load(id_is_load), .id_is_mc(id_is_mc),
    .flush(flush), .stall(stall), .bubble(bubble),
    .fwd_sel_r2(fwd_sel_r2), .fwd_sel_r3(fwd_sel_r3), .mc_busy(mc_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: list of instructions in EX(0), MEM(1), WB(2), plus the number
  // of remaining multi-cycle stall cycles and a flag for the one-cycle load wait.
  typedef struct {bit v; int rd; bit wr; bit ld;} ent_t;
  ent_t pipe[3];
  ent_t nxt_pipe[3];
  int   mc_left = 0, nxt_mc = 0;
  bit   ld_wait = 1'b0, nxt_ld = 1'b0;

  function automatic bit hits(ent_t e, int src, bit use_src);
    return e.v && e.wr && e.rd == src && use_src && !(ZERO_EN && src == 0);
  endfunction

  function automatic int m_sel(int src, bit use_src);
    for (int s = 0; s < 3; s++)
      if (hits(pipe[s], src, use_src) && !(s == 0 && pipe[0].ld)) return 3 - s;
    return 0;
  endfunction

  always @(negedge clk) begin
    bit haz, in_mc, e_stall, e_bubble;
    ent_t empty;
    empty = '{0, 0, 0, 0};
    in_mc = mc_left > 0;
    haz = id_valid && pipe[0].ld &&
          (hits(pipe[0], int'(id_rs2), id_use_rs2) || hits(pipe[0], int'(id_rs3), id_use_rs3));
    e_stall  = in_mc || (!ld_wait && !flush && haz);
    e_bubble = !in_mc && !ld_wait && (flush || haz);
    check("model_stall", {3'b0, stall}, {3'b0, e_stall});
    check("model_bubble", {3'b0, bubble}, {3'b0, e_bubble});
    check("model_mc_busy", {3'b0, mc_busy}, {3'b0, in_mc});
    check("model_fwd_r2", {2'b0, fwd_sel_r2}, 4'(m_sel(int'(id_rs2), id_use_rs2)));
    check("model_fwd_r3", {2'b0, fwd_sel_r3}, 4'(m_sel(int'(id_rs3), id_use_rs3)));
    nxt_pipe[2] = pipe[1];
    if (in_mc) begin
      nxt_pipe[1] = empty;
      nxt_pipe[0] = pipe[0];
      nxt_mc = mc_left - 1;
      nxt_ld = 1'b0;
    end else begin
      nxt_pipe[1] = pipe[0];
      nxt_pipe[0] = e_bubble ? empty : '{id_valid, int'(id_rd), id_wr, id_is_load};
      nxt_mc = (!e_bubble && id_valid && id_is_mc) ? MC_CYCLES - 1 : 0;
      nxt_ld = !ld_wait && !flush && haz;
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < 3; s++) pipe[s] = '{0, 0, 0, 0};
      mc_left = 0;
      ld_wait = 1'b0;
    end else begin
      pipe    = nxt_pipe;
      mc_left = nxt_mc;
      ld_wait = nxt_ld;
    end
  end

  // Drive one cycle of ID inputs just after the edge; return just after the
  // following falling edge so literal checks see settled outputs.
  task automatic drive(input bit v, input int rs2, input bit u2, input int rs3, input bit u3,
                       input int rd, input bit wr, input bit ld, input bit mc, input bit fl);
    @(posedge clk); #1;
    id_valid = v;  id_rs2 = rs2[REG_AW-1:0]; id_use_rs2 = u2;
    id_rs3 = rs3[REG_AW-1:0]; id_use_rs3 = u3; id_rd = rd[REG_AW-1:0];
    id_wr = wr; id_is_load = ld; id_is_mc = mc; flush = fl;
    @(negedge clk); #1;
  endtask

  task automatic nops(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    #12;
    check("reset_stall", {3'b0, stall}, 4'd0);
    check("reset_bubble", {3'b0, bubble}, 4'd0);
    check("reset_fwd_r2", {2'b0, fwd_sel_r2}, 4'd0);
    check("reset_fwd_r3", {2'b0, fwd_sel_r3}, 4'd0);
    check("reset_mc_busy", {3'b0, mc_busy}, 4'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // ALU chain: three writers of r3, then a reader held in ID for four cycles
    for (int i = 0; i < 3; i++) drive(1, 0, 0, 0, 0, 3, 1, 0, 0, 0);
    drive(1, 3, 1, 0, 0, 12, 0, 0, 0, 0);
    check("alu_fwd_ex", {2'b0, fwd_sel_r2}, 4'd3);
    drive(1, 3, 1, 0, 0, 12, 0, 0, 0, 0);
    check("alu_fwd_mem", {2'b0, fwd_sel_r2}, 4'd2);
    drive(1, 3, 1, 0, 0, 12, 0, 0, 0, 0);
    check("alu_fwd_wb", {2'b0, fwd_sel_r2}, 4'd1);
    drive(1, 3, 1, 0, 0, 12, 0, 0, 0, 0);
    check("alu_fwd_rf", {2'b0, fwd_sel_r2}, 4'd0);
    nops(3);

    // Load-use on rs3
    drive(1, 0, 0, 0, 0, 5, 1, 1, 0, 0);
    drive(1, 0, 0, 5, 1, 8, 1, 0, 0, 0);
    check("ldu_stall", {3'b0, stall}, 4'd1);
    check("ldu_bubble", {3'b0, bubble}, 4'd1);
    drive(1, 0, 0, 5, 1, 8, 1, 0, 0, 0);
    check("ldu_release_stall", {3'b0, stall}, 4'd0);
    check("ldu_release_bubble", {3'b0, bubble}, 4'd0);
    check("ldu_fwd_mem", {2'b0, fwd_sel_r3}, 4'd2);
    nops(3);

    // Two back-to-back multi-cycle ops, the second reading the first's result
    drive(1, 0, 0, 0, 0, 7, 1, 0, 1, 0);
    check("mc_entry_stall", {3'b0, stall}, 4'd0);
    for (int i = 0; i < MC_CYCLES - 1; i++) begin
      drive(1, 7, 1, 0, 0, 10, 1, 0, 1, 0);
      check("mc1_stall", {3'b0, stall}, 4'd1);
      check("mc1_busy", {3'b0, mc_busy}, 4'd1);
    end
    drive(1, 7, 1, 0, 0, 10, 1, 0, 1, 0);
    check("mc1_done_stall", {3'b0, stall}, 4'd0);
    check("mc1_done_busy", {3'b0, mc_busy}, 4'd0);
    check("mc1_fwd_ex", {2'b0, fwd_sel_r2}, 4'd3);
    for (int i = 0; i < MC_CYCLES - 1; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      check("mc2_busy", {3'b0, mc_busy}, 4'd1);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("mc2_done_busy", {3'b0, mc_busy}, 4'd0);
    nops(3);

    // Flush in the same cycle as a load-use hazard
    drive(1, 0, 0, 0, 0, 5, 1, 1, 0, 0);
    drive(1, 5, 1, 0, 0, 6, 1, 0, 0, 1);
    check("flush_bubble", {3'b0, bubble}, 4'd1);
    check("flush_stall", {3'b0, stall}, 4'd0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("flush_after_stall", {3'b0, stall}, 4'd0);
    nops(3);

    // Zero register
    drive(1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    drive(1, 0, 1, 0, 0, 4, 0, 0, 0, 0);
    check("zero_reg_fwd", {2'b0, fwd_sel_r2}, ZERO_EN ? 4'd0 : 4'd3);
    nops(3);

    // Randomized traffic, checked by the model every cycle
    for (int i = 0; i < 600; i++) begin
      bit mc, ld;
      mc = ($urandom_range(0, 9) == 0);
      ld = !mc && ($urandom_range(0, 3) == 0);
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 3), $urandom_range(0, 1),
            $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 3),
            $urandom_range(0, 1), ld, mc, $urandom_range(0, 11) == 0);
    end
    nops(MC_CYCLES + 3);

    // Asynchronous reset in the middle of a multi-cycle op (counter at 2)
    drive(1, 0, 0, 0, 0, 9, 1, 0, 1, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("pre_reset_busy", {3'b0, mc_busy}, 4'd1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    #1;
    check("async_rst_stall", {3'b0, stall}, 4'd0);
    check("async_rst_busy", {3'b0, mc_busy}, 4'd0);
    check("async_rst_bubble", {3'b0, bubble}, 4'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk); #1;
    check("post_rst_stall", {3'b0, stall}, 4'd0);
    check("post_rst_busy", {3'b0, mc_busy}, 4'd0);
    nops(2);
    check("post_rst_idle", {3'b0, mc_busy}, 4'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
